brouter: RTL and testbench

BROUTER -- requirements
Module: brouter

---
 rtl/brouter_pkg.sv | 63 ++++++
 rtl/brouter_bless_alloc.sv | 67 ++++++
 rtl/brouter.sv | 112 +++++++++++
 tb/tb_brouter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brouter_pkg.sv
// Shared types, header field positions and routing helpers for the
// bufferless deflection router.
package brouter_pkg;

    localparam int CONTROL_W = 28;
    localparam int DATA_W    = 128;
    localparam int AGE_W     = 16;

    localparam int HDR_VALID = 27;
    localparam int HDR_DX_HI = 23;
    localparam int HDR_DX_LO = 20;
    localparam int HDR_DY_HI = 19;
    localparam int HDR_DY_LO = 16;

    localparam int NPORTS = 5;
    localparam int NNET   = 4;

    typedef logic [2:0] port_t;

    localparam port_t PORT_N    = 3'd0;
    localparam port_t PORT_E    = 3'd1;
    localparam port_t PORT_S    = 3'd2;
    localparam port_t PORT_W    = 3'd3;
    localparam port_t PORT_L    = 3'd4;
    localparam port_t PORT_NONE = 3'd7;

    function automatic port_t xy_route(
        input logic [CONTROL_W-1:0] hdr,
        input logic [3:0]           my_x,
        input logic [3:0]           my_y
    );
        logic [3:0] dx;
        logic [3:0] dy;
        dx = hdr[HDR_DX_HI:HDR_DX_LO];
        dy = hdr[HDR_DY_HI:HDR_DY_LO];
        if (dx > my_x)      return PORT_E;
        else if (dx < my_x) return PORT_W;
        else if (dy > my_y) return PORT_S;
        else if (dy < my_y) return PORT_N;
        else                return PORT_L;
    endfunction

    function automatic port_t lowest_free(input logic [3:0] busy);
        port_t r;
        r = PORT_NONE;
        for (int i = NNET - 1; i >= 0; i--) begin
            if (!busy[i]) r = port_t'(i);
        end
        return r;
    endfunction

    // Forwarded flits age by one (saturating); ejected flits keep their age.
    function automatic logic [CONTROL_W-1:0] out_hdr(
        input logic [CONTROL_W-1:0] hdr,
        input logic                 eject
    );
        logic [AGE_W-1:0] age;
        age = hdr[AGE_W-1:0];
        if (!eject && age != {AGE_W{1'b1}}) age = age + 1'b1;
        return {hdr[CONTROL_W-1:AGE_W], age};
    endfunction

endpackage

// File: rtl/brouter_bless_alloc.sv
// Combinational age ranking, XY routing and deflection port allocation.
// Grants use PORT_NONE for inputs that receive no output.
module bless_alloc
    import brouter_pkg::*;
#(
    parameter logic [3:0] MY_X = 4'd0,
    parameter logic [3:0] MY_Y = 4'd0
) (
    input  logic [CONTROL_W-1:0] hdr_i [NPORTS],
    output port_t                grant_o [NPORTS],
    output logic                 ready_o
);

    logic [1:0] rank [NNET];
    logic [7:0] busy;
    port_t      pp;
    logic       unused_hdr;

    always_comb begin
        unused_hdr = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            unused_hdr = unused_hdr ^ (^hdr_i[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < NNET; i++) begin
            rank[i] = 2'd0;
            for (int j = 0; j < NNET; j++) begin
                if (j != i && hdr_i[j][HDR_VALID] &&
                    (hdr_i[j][AGE_W-1:0] > hdr_i[i][AGE_W-1:0] ||
                     (hdr_i[j][AGE_W-1:0] == hdr_i[i][AGE_W-1:0] &&
                      j < i))) begin
                    rank[i] = rank[i] + 2'd1;
                end
            end
        end
    end

    // Four network flits always fit in the four network ports.
    always_comb begin
        busy    = 8'd0;
        pp      = PORT_NONE;
        ready_o = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            grant_o[i] = PORT_NONE;
        end
        for (int r = 0; r < NNET; r++) begin
            for (int i = 0; i < NNET; i++) begin
                if (hdr_i[i][HDR_VALID] && rank[i] == 2'(r)) begin
                    pp = xy_route(hdr_i[i], MY_X, MY_Y);
                    if (busy[pp]) pp = lowest_free(busy[3:0]);
                    grant_o[i] = pp;
                    busy[pp]   = 1'b1;
                end
            end
        end
        ready_o = ~&busy[3:0];
        if (hdr_i[PORT_L][HDR_VALID] && ready_o) begin
            pp = xy_route(hdr_i[PORT_L], MY_X, MY_Y);
            if (busy[pp]) pp = lowest_free(busy[3:0]);
            grant_o[PORT_L] = pp;
            busy[pp]        = 1'b1;
        end
    end

endmodule

// File: rtl/brouter.sv
// Bufferless deflection router: registered header stage plus a payload
// stage steered one cycle later by the header's grant.
module brouter
    import brouter_pkg::*;
#(
    parameter logic [3:0] MY_X = 4'd0,
    parameter logic [3:0] MY_Y = 4'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [27:0]  port0_ci,
    input  logic [27:0]  port1_ci,
    input  logic [27:0]  port2_ci,
    input  logic [27:0]  port3_ci,
    input  logic [27:0]  port4_ci,
    input  logic [127:0] port0_di,
    input  logic [127:0] port1_di,
    input  logic [127:0] port2_di,
    input  logic [127:0] port3_di,
    input  logic [127:0] port4_di,
    output logic [27:0]  port0_co,
    output logic [27:0]  port1_co,
    output logic [27:0]  port2_co,
    output logic [27:0]  port3_co,
    output logic [27:0]  port4_co,
    output logic [127:0] port0_do,
    output logic [127:0] port1_do,
    output logic [127:0] port2_do,
    output logic [127:0] port3_do,
    output logic [127:0] port4_do,
    output logic         port4_ready
);

    logic [CONTROL_W-1:0] ci      [NPORTS];
    logic [DATA_W-1:0]    di      [NPORTS];
    logic [CONTROL_W-1:0] co_d    [NPORTS];
    logic [CONTROL_W-1:0] co_q    [NPORTS];
    logic [DATA_W-1:0]    do_d    [NPORTS];
    logic [DATA_W-1:0]    do_q    [NPORTS];
    port_t                grant   [NPORTS];
    port_t                steer_q [NPORTS];

    assign ci[0] = port0_ci;
    assign ci[1] = port1_ci;
    assign ci[2] = port2_ci;
    assign ci[3] = port3_ci;
    assign ci[4] = port4_ci;
    assign di[0] = port0_di;
    assign di[1] = port1_di;
    assign di[2] = port2_di;
    assign di[3] = port3_di;
    assign di[4] = port4_di;

    bless_alloc #(
        .MY_X (MY_X),
        .MY_Y (MY_Y)
    ) u_alloc (
        .hdr_i   (ci),
        .grant_o (grant),
        .ready_o (port4_ready)
    );

    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            co_d[k] = '0;
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i] <= PORT_L) begin
                co_d[grant[i]] = out_hdr(ci[i], grant[i] == PORT_L);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            do_d[k] = '0;
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (steer_q[i] <= PORT_L) begin
                do_d[steer_q[i]] = di[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NPORTS; k++) begin
                co_q[k]    <= '0;
                do_q[k]    <= '0;
                steer_q[k] <= PORT_NONE;
            end
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                co_q[k]    <= co_d[k];
                do_q[k]    <= do_d[k];
                steer_q[k] <= grant[k];
            end
        end
    end

    assign port0_co = co_q[0];
    assign port1_co = co_q[1];
    assign port2_co = co_q[2];
    assign port3_co = co_q[3];
    assign port4_co = co_q[4];
    assign port0_do = do_q[0];
    assign port1_do = do_q[1];
    assign port2_do = do_q[2];
    assign port3_do = do_q[3];
    assign port4_do = do_q[4];

endmodule

// File: tb/tb_brouter.sv
// Directed and randomized checks of brouter against a priority-order
// reference model of the deflection allocator.
module tb_brouter;

    localparam logic [3:0] MYX = 4'd0;
    localparam logic [3:0] MYY = 4'd0;
    localparam logic [127:0] PAY = 128'h0123456789abcdef0123456789abcdef;

    logic         clk;
    logic         rst;
    logic [27:0]  ci   [5];
    logic [127:0] di   [5];
    logic [27:0]  co   [5];
    logic [127:0] dout [5];
    logic         port4_ready;

    int tests;
    int fails;

    int m_port    [5];
    int prev_port [5];
    bit m_ready;
    logic [27:0]  exp_co [5];
    logic [127:0] exp_do [5];

    brouter #(.MY_X(MYX), .MY_Y(MYY)) dut (
        .clk         (clk),
        .rst         (rst),
        .port0_ci    (ci[0]),
        .port1_ci    (ci[1]),
        .port2_ci    (ci[2]),
        .port3_ci    (ci[3]),
        .port4_ci    (ci[4]),
        .port0_di    (di[0]),
        .port1_di    (di[1]),
        .port2_di    (di[2]),
        .port3_di    (di[3]),
        .port4_di    (di[4]),
        .port0_co    (co[0]),
        .port1_co    (co[1]),
        .port2_co    (co[2]),
        .port3_co    (co[3]),
        .port4_co    (co[4]),
        .port0_do    (dout[0]),
        .port1_do    (dout[1]),
        .port2_do    (dout[2]),
        .port3_do    (dout[3]),
        .port4_do    (dout[4]),
        .port4_ready (port4_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int route(logic [27:0] h);
        if (h[23:20] > MYX) return 1;
        if (h[23:20] < MYX) return 3;
        if (h[19:16] > MYY) return 2;
        if (h[19:16] < MYY) return 0;
        return 4;
    endfunction

    function automatic logic [27:0] bump(logic [27:0] h);
        logic [15:0] a;
        a = (h[15:0] == 16'hFFFF) ? 16'hFFFF : h[15:0] + 16'd1;
        return {h[27:16], a};
    endfunction

    // Serve flits oldest first; a taken productive port means the lowest free network port.
    task automatic model_alloc();
        bit taken [5];
        bit done  [4];
        int best;
        int pp;
        for (int i = 0; i < 5; i++) begin
            m_port[i] = -1;
            taken[i]  = 1'b0;
        end
        for (int i = 0; i < 4; i++) done[i] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            best = -1;
            for (int i = 0; i < 4; i++) begin
                if (ci[i][27] && !done[i]) begin
                    if (best < 0 || ci[i][15:0] > ci[best][15:0]) best = i;
                end
            end
            if (best >= 0) begin
                done[best] = 1'b1;
                pp = route(ci[best]);
                if (taken[pp]) begin
                    pp = 0;
                    while (taken[pp]) pp++;
                end
                taken[pp]    = 1'b1;
                m_port[best] = pp;
            end
        end
        m_ready = !(taken[0] && taken[1] && taken[2] && taken[3]);
        if (ci[4][27] && m_ready) begin
            pp = route(ci[4]);
            if (taken[pp]) begin
                pp = 0;
                while (taken[pp]) pp++;
            end
            m_port[4] = pp;
        end
    endtask

    task automatic run_cycle();
        model_alloc();
        for (int p = 0; p < 5; p++) begin
            exp_co[p] = '0;
            exp_do[p] = '0;
        end
        for (int i = 0; i < 5; i++) begin
            if (m_port[i] == 4) exp_co[4] = ci[i];
            else if (m_port[i] >= 0) exp_co[m_port[i]] = bump(ci[i]);
            if (prev_port[i] >= 0) exp_do[prev_port[i]] = di[i];
        end
        #1;
        chk("ready", {127'd0, port4_ready}, {127'd0, m_ready});
        @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++) begin
            chk($sformatf("co%0d", p), {100'd0, co[p]}, {100'd0, exp_co[p]});
            chk($sformatf("do%0d", p), dout[p], exp_do[p]);
        end
        for (int i = 0; i < 5; i++) prev_port[i] = m_port[i];
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 5; i++) begin
            ci[i] = '0;
            di[i] = '0;
        end
    endtask

    initial begin
        int hits;
        logic [27:0] inj;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 5; i++) prev_port[i] = -1;
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++) begin
            chk("rst_co", {100'd0, co[p]}, 128'd0);
            chk("rst_do", dout[p], 128'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Three southbound flits, oldest wins port 2
        ci[0] = 28'h8010001;
        ci[1] = 28'h8040002;
        ci[2] = 28'h8060003;
        run_cycle();
        chk("ex1_p2", {100'd0, co[2]}, 128'h8060004);
        chk("ex1_p0", {100'd0, co[0]}, 128'h8040003);
        chk("ex1_p1", {100'd0, co[1]}, 128'h8010002);
        chk("ex1_p3", {100'd0, co[3]}, 128'd0);
        chk("ex1_p4", {100'd0, co[4]}, 128'd0);
        clear_inputs();
        di[0] = PAY;
        di[1] = PAY;
        di[2] = PAY;
        run_cycle();
        chk("ex1_d0", dout[0], PAY);
        chk("ex1_d1", dout[1], PAY);
        chk("ex1_d2", dout[2], PAY);
        chk("ex1_d3", dout[3], 128'd0);
        chk("ex1_d4", dout[4], 128'd0);
        clear_inputs();
        run_cycle();

        // Two local flits, one eject
        ci[0] = 28'h8000005;
        ci[1] = 28'h8000007;
        run_cycle();
        chk("ej_p4", {100'd0, co[4]}, 128'h8000007);
        chk("ej_p0", {100'd0, co[0]}, 128'h8000006);
        clear_inputs();
        run_cycle();

        // Full network: inject must be dropped
        ci[0] = 28'h8100011;
        ci[1] = 28'h8100012;
        ci[2] = 28'h8200013;
        ci[3] = 28'h8300014;
        inj   = 28'hD010ABC;
        ci[4] = inj;
        #1;
        chk("full_rdy", {127'd0, port4_ready}, 128'd0);
        run_cycle();
        hits = 0;
        for (int p = 0; p < 5; p++) begin
            if (co[p] == inj || co[p] == bump(inj)) hits++;
        end
        chk("drop_hdr", 128'(hits), 128'd0);
        clear_inputs();
        di[4] = ~PAY;
        run_cycle();
        hits = 0;
        for (int p = 0; p < 5; p++) if (dout[p] == ~PAY) hits++;
        chk("drop_pay", 128'(hits), 128'd0);
        clear_inputs();
        run_cycle();

        // Equal age tie on port 1
        ci[1] = 28'h8100009;
        ci[3] = 28'h8120009;
        run_cycle();
        chk("tie_p1", {100'd0, co[1]}, 128'h810000A);
        chk("tie_p0", {100'd0, co[0]}, 128'h812000A);
        clear_inputs();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 5; i++) begin
                logic [15:0] age;
                case ($urandom_range(0, 3))
                    0: age = 16'(($urandom_range(0, 3)));
                    1: age = 16'hFFFF;
                    default: age = 16'($urandom);
                endcase
                ci[i] = {($urandom_range(0, 9) < 6), 3'($urandom),
                         4'($urandom_range(0, 2)),
                         4'($urandom_range(0, 2)), age};
                di[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            run_cycle();
        end
        clear_inputs();
        run_cycle();

        // Reset between header and payload
        ci[0] = 28'h8010020;
        run_cycle();
        clear_inputs();
        di[0] = PAY;
        #2;
        rst = 1'b0;
        #1;
        for (int p = 0; p < 5; p++) begin
            chk("arst_co", {100'd0, co[p]}, 128'd0);
            chk("arst_do", dout[p], 128'd0);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++) chk("rsth_do", dout[p], 128'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) prev_port[i] = -1;
        run_cycle();
        for (int p = 0; p < 5; p++) chk("post_do", dout[p], 128'd0);
        clear_inputs();
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
